jtvigil_gfx_rom_resp: RTL

- Responder side of the scroll-layer ROM handshake (rom_addr/rom_cs/rom_data/rom_ok) used by the scr1 and scr2 tile engines.
- Serves both requesters from one 16-bit SDRAM read channel.
- Holds a one-word cache per requester and arbitrates misses round-robin.
- Assembles each 32-bit word from two 16-bit beats before returning it with ok.

---
 rtl/jtvigil_gfx_rom_resp.sv | 131 +++++++++++++
 1 files changed

// File: rtl/jtvigil_gfx_rom_resp.sv
// Scroll-layer ROM responder: one-word cache per requester, round-robin miss fill over a 16-bit SDRAM channel.
// Optional miss statistics counter enabled by defining JTVIGIL_ROMRESP_STATS_EN.
module jtvigil_gfx_rom_resp #(
  parameter int              AW1     = 17,
  parameter int              AW2     = 18,
  parameter int              SAW     = 22,
  parameter logic [SAW-1:0]  OFFSET2 = 22'h04_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW1-1:0]  scr1_addr,
  input  logic            scr1_cs,
  output logic [31:0]     scr1_data,
  output logic            scr1_ok,
  input  logic [AW2-1:0]  scr2_addr,
  input  logic            scr2_cs,
  output logic [31:0]     scr2_data,
  output logic            scr2_ok,
  output logic [SAW-1:0]  sdram_addr,
  output logic            sdram_req,
  input  logic            sdram_ack,
  input  logic            sdram_dst,
  input  logic            sdram_rdy,
  input  logic [15:0]     sdram_din,
  output logic [15:0]     st_miss
);

  typedef enum logic [1:0] {IDLE, REQ, BEAT0, BEAT1} state_t;

  state_t          state_q;
  logic [AW1-1:0]  tag1_q;
  logic [AW2-1:0]  tag2_q;
  logic            valid1_q, valid2_q;
  logic [31:0]     data1_q, data2_q;
  logic            slot_q;
  logic            rr_q;
  logic [AW2-1:0]  lat_q;
  logic [15:0]     low_q;
  logic            req_q;
  logic [SAW-1:0]  addr_q;

  logic            hit1, hit2, miss1, miss2, any_miss, beat;
  logic            slot_d;
  logic [AW2-1:0]  lat_d;
  logic [SAW-1:0]  addr_d;

  assign hit1     = valid1_q && (tag1_q == scr1_addr);
  assign hit2     = valid2_q && (tag2_q == scr2_addr);
  assign miss1    = scr1_cs && !hit1;
  assign miss2    = scr2_cs && !hit2;
  assign any_miss = miss1 || miss2;
  assign beat     = sdram_dst && sdram_rdy;

  // rr_q names the slot preferred on a double miss: the one not served last
  assign slot_d = miss2 && (!miss1 || rr_q);
  assign lat_d  = slot_d ? scr2_addr : AW2'(scr1_addr);
  assign addr_d = slot_d ? (OFFSET2 + SAW'({scr2_addr, 1'b0})) : SAW'({scr1_addr, 1'b0});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      addr_q   <= '0;
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
      tag1_q   <= '0;
      tag2_q   <= '0;
      data1_q  <= '0;
      data2_q  <= '0;
      rr_q     <= 1'b0;
      slot_q   <= 1'b0;
      lat_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (any_miss) begin
          slot_q  <= slot_d;
          lat_q   <= lat_d;
          addr_q  <= addr_d;
          req_q   <= 1'b1;
          state_q <= REQ;
        end
        REQ: if (sdram_ack) begin
          req_q   <= 1'b0;
          state_q <= BEAT0;
        end
        BEAT0: if (beat) begin
          low_q   <= sdram_din;
          state_q <= BEAT1;
        end
        BEAT1: if (beat) begin
          if (slot_q) begin
            data2_q  <= {sdram_din, low_q};
            tag2_q   <= lat_q;
            valid2_q <= 1'b1;
          end else begin
            data1_q  <= {sdram_din, low_q};
            tag1_q   <= lat_q[AW1-1:0];
            valid1_q <= 1'b1;
          end
          rr_q    <= ~slot_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign scr1_data  = data1_q;
  assign scr2_data  = data2_q;
  assign scr1_ok    = scr1_cs && hit1;
  assign scr2_ok    = scr2_cs && hit2;
  assign sdram_addr = addr_q;
  assign sdram_req  = req_q;

`ifdef JTVIGIL_ROMRESP_STATS_EN
  logic [15:0] miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      miss_cnt_q <= '0;
    end else if (state_q == IDLE && any_miss && miss_cnt_q != 16'hFFFF) begin
      miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign st_miss = miss_cnt_q;
`else
  assign st_miss = '0;
`endif

endmodule
